// File: rtl/riscv_pkg.sv
// Shared fetch-side types: data widths, the buffered fetch entry and the fetch FSM states.
// Imported by the fetch buffer and the fetch unit.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry circular fetch buffer; head visible combinationally, push/pop take effect at the edge.
// A push is accepted when full only if a pop frees the head slot in the same cycle; flush wins over both.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  fetch_entry_t                 push_dat_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         head_vld_o,
  output fetch_entry_t                 head_dat_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_entry_t    mem_q [DEPTH];
  fetch_entry_t    mem_d [DEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push;
  logic            do_pop;

  always_comb begin
    do_pop  = pop_i && (count_q != '0) && !flush_i;
    do_push = push_i && ((count_q != FULL) || do_pop) && !flush_i;
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // When full, tail == head: the popped head slot is reused by the push.
      if (do_push) begin
        mem_d[tail_q] = push_dat_i;
        tail_d        = (tail_q == LAST) ? '0 : tail_q + 1'b1;
      end
      if (do_pop) begin
        head_d = (head_q == LAST) ? '0 : head_q + 1'b1;
      end
      if (do_push && !do_pop) begin
        count_d = count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign count_o    = count_q;
  assign head_vld_o = (count_q != '0);
  assign head_dat_o = head_vld_o ? mem_q[head_q] : '0;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: PC register feeding a combinational imem, results queued in fetch_fifo; 1 cycle PC-to-valid.
// Fetch stalls while the buffer is full unless decode pops the head in the same cycle; redirect flushes everything.
module ifetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [ILEN-1:0] imem_instr_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [ILEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            fetch;
  logic            pop;
  logic            head_vld;
  fetch_entry_t    head_dat;
  fetch_entry_t    push_dat;
  logic [CW-1:0]   fifo_count;

  always_comb begin
    pop      = head_vld && ready_i && !redirect_i;
    fetch    = (state_q == RUN) && !redirect_i && ((fifo_count != CW'(DEPTH)) || pop);
    state_d  = en_i ? RUN : IDLE;
    push_dat = '{pc: pc_q, instr: imem_instr_i};
    pc_d     = pc_q;
    if (redirect_i) begin
      pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
    end else if (fetch) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pc_q    <= {RESET_PC[XLEN-1:2], 2'b00};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fetch_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (fetch),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .flush_i    (redirect_i),
    .count_o    (fifo_count),
    .head_vld_o (head_vld),
    .head_dat_o (head_dat)
  );

  assign imem_addr_o = pc_q;
  assign valid_o     = head_vld;
  assign instr_o     = head_dat.instr;
  assign pc_o        = head_dat.pc;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios plus randomized traffic against a queue-based reference model.
// A second instance with RESET_PC near the top of the address space covers PC wrap.
module tb_ifetch_unit;

  logic        clk;
  logic        rst, en, redirect, ready;
  logic [31:0] redirect_pc, imem_addr, imem_instr, instr, pc;
  logic        valid;

  logic        w_rst, w_en, w_ready, w_valid;
  logic [31:0] w_imem_addr, w_imem_instr, w_instr, w_pc;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  bit          m_run;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  assign imem_instr   = mem_word(imem_addr);
  assign w_imem_instr = mem_word(w_imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ifetch_unit dut (
    .clk_i(clk), .rst_i(rst), .en_i(en),
    .imem_addr_o(imem_addr), .imem_instr_i(imem_instr),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .valid_o(valid), .ready_i(ready), .instr_o(instr), .pc_o(pc)
  );

  ifetch_unit #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) dut_w (
    .clk_i(clk), .rst_i(w_rst), .en_i(w_en),
    .imem_addr_o(w_imem_addr), .imem_instr_i(w_imem_instr),
    .redirect_i(1'b0), .redirect_pc_i(32'h0),
    .valid_o(w_valid), .ready_i(w_ready), .instr_o(w_instr), .pc_o(w_pc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0444;
    tick();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", instr); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", pc); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", imem_addr); end
    rst = 1'b0; redirect = 1'b0; en = 1'b0; ready = 1'b0;
  endtask

  task automatic test_stream();
    do_reset();
    en = 1'b1; ready = 1'b1;
    tick();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL stream_enter_run valid got %b want 0", valid); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (valid !== 1'b1 || pc !== 32'(4 * i) || instr !== mem_word(32'(4 * i))) begin
        errors++;
        $display("FAIL stream_%0d got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                 i, valid, pc, instr, 32'(4 * i), mem_word(32'(4 * i)));
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    en = 1'b1; ready = 1'b0;
    repeat (5) tick();
    checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL stall_addr got %h want 8", imem_addr); end
    checks++; if (valid !== 1'b1 || pc !== 32'h0) begin errors++; $display("FAIL stall_head got v=%b pc=%h want v=1 pc=0", valid, pc); end
    ready = 1'b1;
    tick();
    checks++; if (pc !== 32'h4 || instr !== mem_word(32'h4)) begin errors++; $display("FAIL stall_drain1 got pc=%h want 4", pc); end
    ready = 1'b0;
    tick();
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL stall_hold got pc=%h want 4", pc); end
    ready = 1'b1;
    tick();
    checks++; if (pc !== 32'h8 || instr !== mem_word(32'h8)) begin errors++; $display("FAIL stall_drain2 got pc=%h want 8", pc); end
    ready = 1'b0;
  endtask

  task automatic test_redirect();
    do_reset();
    en = 1'b1; ready = 1'b0;
    repeat (4) tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0023;
    tick();
    redirect = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL redirect_flush got v=%b want 0", valid); end
    checks++; if (imem_addr !== 32'h20) begin errors++; $display("FAIL redirect_addr got %h want 20", imem_addr); end
    tick();
    checks++; if (valid !== 1'b1 || pc !== 32'h20 || instr !== mem_word(32'h20)) begin
      errors++; $display("FAIL redirect_first got v=%b pc=%h want v=1 pc=20", valid, pc);
    end
  endtask

  task automatic test_redirect_vs_pop();
    do_reset();
    en = 1'b1; ready = 1'b0;
    repeat (3) tick();
    ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0100;
    tick();
    redirect = 1'b0; ready = 1'b0;
    checks++; if (valid !== 1'b0 || imem_addr !== 32'h100) begin
      errors++; $display("FAIL redirect_pop got v=%b addr=%h want v=0 addr=100", valid, imem_addr);
    end
    tick();
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL redirect_pop_next got pc=%h want 100", pc); end
  endtask

  task automatic test_disable();
    do_reset();
    en = 1'b1; ready = 1'b0;
    repeat (4) tick();
    en = 1'b0;
    tick();
    checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL disable_hold got %h want 8", imem_addr); end
    ready = 1'b1;
    tick();
    checks++; if (valid !== 1'b1 || pc !== 32'h4) begin errors++; $display("FAIL disable_drain got v=%b pc=%h want v=1 pc=4", valid, pc); end
    tick();
    checks++; if (valid !== 1'b0 || imem_addr !== 32'h8) begin
      errors++; $display("FAIL disable_empty got v=%b addr=%h want v=0 addr=8", valid, imem_addr);
    end
    repeat (3) tick();
    checks++; if (valid !== 1'b0 || imem_addr !== 32'h8) begin
      errors++; $display("FAIL disable_idle got v=%b addr=%h want v=0 addr=8", valid, imem_addr);
    end
    ready = 1'b0;
  endtask

  task automatic test_wrap();
    w_rst = 1'b1; w_en = 1'b0; w_ready = 1'b0;
    tick();
    w_rst = 1'b0;
    checks++; if (w_imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_reset_addr got %h want fffffffc", w_imem_addr); end
    w_en = 1'b1;
    repeat (3) tick();
    checks++; if (w_pc !== 32'hFFFF_FFFC || w_instr !== mem_word(32'hFFFF_FFFC)) begin
      errors++; $display("FAIL wrap_first got pc=%h want fffffffc", w_pc);
    end
    checks++; if (w_imem_addr !== 32'h4) begin errors++; $display("FAIL wrap_addr got %h want 4", w_imem_addr); end
    w_ready = 1'b1;
    tick();
    checks++; if (w_pc !== 32'h0 || w_instr !== mem_word(32'h0)) begin errors++; $display("FAIL wrap_second got pc=%h want 0", w_pc); end
    w_ready = 1'b0;
    repeat (3) tick();
    w_rst = 1'b1; w_ready = 1'b1;
    tick();
    w_rst = 1'b0;
    checks++; if (w_valid !== 1'b0 || w_imem_addr !== 32'hFFFF_FFFC || w_pc !== 32'h0) begin
      errors++; $display("FAIL wrap_midstall_reset got v=%b addr=%h pc=%h want v=0 addr=fffffffc pc=0", w_valid, w_imem_addr, w_pc);
    end
  endtask

  task automatic test_random();
    bit pop_m, fetch_m;
    ent_t e;
    do_reset();
    mq.delete(); m_pc = 32'h0; m_run = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst      = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 9) == 0) en = ~en;
      ready    = ($urandom_range(0, 2) != 0);
      redirect = (en == m_run) && ($urandom_range(0, 14) == 0);
      redirect_pc = $urandom;
      if (rst) begin
        mq.delete(); m_pc = 32'h0; m_run = 1'b0;
      end else if (redirect) begin
        mq.delete(); m_pc = redirect_pc & 32'hFFFF_FFFC; m_run = en;
      end else begin
        pop_m   = (mq.size() > 0) && ready;
        fetch_m = m_run && ((mq.size() < 2) || pop_m);
        if (pop_m) void'(mq.pop_front());
        if (fetch_m) begin
          mq.push_back('{pc: m_pc, instr: mem_word(m_pc)});
          m_pc = m_pc + 32'd4;
        end
        m_run = en;
      end
      tick();
      e = (mq.size() > 0) ? mq[0] : '0;
      checks++;
      if (valid !== (mq.size() > 0) || pc !== e.pc || instr !== e.instr || imem_addr !== m_pc) begin
        errors++;
        $display("FAIL random_cyc%0d got v=%b pc=%h instr=%h addr=%h want v=%b pc=%h instr=%h addr=%h",
                 cyc, valid, pc, instr, imem_addr, (mq.size() > 0), e.pc, e.instr, m_pc);
      end
    end
    rst = 1'b0; redirect = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    w_rst = 1'b1; w_en = 1'b0; w_ready = 1'b0;
    tick();
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_vs_pop();
    test_disable();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
